// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: credit-limited req/gnt/rvalid fetch, PC-tagged instruction FIFO, redirect flush.
// Optional build macro RV32I_FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int unsigned FA_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned QA_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OC_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    logic              fetch_en;
    logic [31:0]       fetch_pc;
    logic [OC_W-1:0]   outstanding;
    logic [OC_W-1:0]   outstanding_nxt;
    logic [OC_W-1:0]   discard;
    logic [31:0]       pcq_mem [MAX_OUTSTANDING];
    logic [QA_W-1:0]   pcq_rd;
    logic [QA_W-1:0]   pcq_wr;
    fetch_entry_t      fifo_mem [FIFO_DEPTH];
    logic [FA_W-1:0]   fifo_rd;
    logic [FA_W-1:0]   fifo_wr;
    logic [FC_W-1:0]   fifo_count;
    logic [31:0]       last_pc;
    fetch_entry_t      fifo_head;
    logic [31:0]       rsp_pc;
    logic              gnt_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              id_fire;
    logic [1:0]        unused_redirect_lsbs;

    function automatic logic [QA_W-1:0] pcq_next(input logic [QA_W-1:0] ptr);
        return (32'(ptr) == MAX_OUTSTANDING - 1) ? '0 : ptr + QA_W'(1);
    endfunction

    assign unused_redirect_lsbs = redirect_pc_i[1:0];

    // fetch_en keeps the request low for the first cycle out of reset.
    assign imem_req_o  = fetch_en && !redirect_i
                         && (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH)
                         && (32'(outstanding) < MAX_OUTSTANDING);
    assign imem_addr_o = fetch_pc;

    assign gnt_fire   = imem_req_o && imem_gnt_i;
    assign rsp_fire   = imem_rvalid_i && (outstanding != '0);
    assign rsp_keep   = rsp_fire && (discard == '0);
    assign rsp_pc     = pcq_mem[pcq_rd];
    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[fifo_rd];
    assign fifo_pop   = !fifo_empty && id_ready_i;
    assign id_fire    = id_valid_o && id_ready_i;

`ifdef RV32I_FETCH_BYPASS_EN
    logic bypass;
    assign bypass = rsp_keep && fifo_empty && !redirect_i;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        id_valid_o = !fifo_empty;
        id_inst_o  = fifo_empty ? NOP_INST : fifo_head.inst;
        id_pc_o    = fifo_empty ? last_pc  : fifo_head.pc;
        fifo_push  = rsp_keep;
`ifdef RV32I_FETCH_BYPASS_EN
        if (bypass) begin
            id_valid_o = 1'b1;
            id_inst_o  = imem_rdata_i;
            id_pc_o    = rsp_pc;
            fifo_push  = !id_ready_i;
        end
`endif
    end

    always_comb begin
        outstanding_nxt = outstanding;
        if (gnt_fire && !rsp_fire) begin
            outstanding_nxt = outstanding + OC_W'(1);
        end else if (!gnt_fire && rsp_fire) begin
            outstanding_nxt = outstanding - OC_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_count  <= '0;
            last_pc     <= RESET_PC;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_nxt;
            if (gnt_fire) pcq_wr <= pcq_next(pcq_wr);
            if (rsp_fire) pcq_rd <= pcq_next(pcq_rd);
            if (id_fire)  last_pc <= id_pc_o;
            // Redirect discards whatever is still in flight once this cycle settles.
            if (redirect_i) begin
                fetch_pc   <= {redirect_pc_i[31:2], 2'b00};
                discard    <= outstanding_nxt;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                fifo_count <= '0;
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_fire && (discard != '0)) discard <= discard - OC_W'(1);
                if (fifo_push) fifo_wr <= fifo_wr + FA_W'(1);
                if (fifo_pop)  fifo_rd <= fifo_rd + FA_W'(1);
                fifo_count <= fifo_count + FC_W'(fifo_push) - FC_W'(fifo_pop);
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (gnt_fire) pcq_mem[pcq_wr] <= fetch_pc;
        if (fifo_push && !redirect_i) fifo_mem[fifo_wr] <= fetch_entry_t'({imem_rdata_i, rsp_pc});
    end

    stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
                                   imem_rvalid_i |-> (outstanding != '0));

endmodule
